// File: rtl/ysyx_22050019_clint.sv
// Core-local interruptor behind an AXI-lite responder: free-running mtime,
// mtimecmp compare and msip, driving the machine timer/software interrupts.
module ysyx_22050019_clint #(
    parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        axi_aw_ready_o,
    input  logic        axi_aw_valid_i,
    input  logic [63:0] axi_aw_addr_i,
    output logic        axi_w_ready_o,
    input  logic        axi_w_valid_i,
    input  logic [63:0] axi_w_data_i,
    input  logic [7:0]  axi_w_strb_i,
    input  logic        axi_b_ready_i,
    output logic        axi_b_valid_o,
    output logic [1:0]  axi_b_resp_o,
    output logic        axi_ar_ready_o,
    input  logic        axi_ar_valid_i,
    input  logic [63:0] axi_ar_addr_i,
    input  logic        axi_r_ready_i,
    output logic        axi_r_valid_o,
    output logic [1:0]  axi_r_resp_o,
    output logic [63:0] axi_r_data_o,
    output logic        timer_irq_o,
    output logic        soft_irq_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } reg_sel_e;

    // Unsigned subtraction wraps addresses below BASE to huge offsets, so a
    // single upper-bound compare covers both edges of the 64 KiB window.
    function automatic reg_sel_e decode(input logic [63:0] addr);
        logic [63:0] off;
        reg_sel_e    sel;
        off = addr - BASE;
        sel = REG_NONE;
        if (off < 64'h0000_0000_0001_0000) begin
            case (off[15:3])
                13'h0000: sel = REG_MSIP;
                13'h0800: sel = REG_MTIMECMP;
                13'h17FF: sel = REG_MTIME;
                default:  sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_val,
                                          input logic [63:0] data,
                                          input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

    logic              aw_held_q, aw_held_d;
    logic [63:0]       aw_addr_q, aw_addr_d;
    logic              w_held_q, w_held_d;
    logic [63:0]       w_data_q, w_data_d;
    logic [7:0]        w_strb_q, w_strb_d;
    logic              b_valid_q, b_valid_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic              r_valid_q, r_valid_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic [63:0]       r_data_q, r_data_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              msip_q, msip_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timer_irq_q, timer_irq_d;

    logic              aw_ready, w_ready, ar_ready;
    logic              aw_hs, w_hs, ar_hs;
    logic              wr_commit, tick;
    logic [63:0]       wr_addr, wr_data;
    logic [7:0]        wr_strb;
    reg_sel_e          wr_sel, rd_sel;

    assign aw_ready = !aw_held_q && !b_valid_q;
    assign w_ready  = !w_held_q && !b_valid_q;
    assign ar_ready = !r_valid_q;

    assign aw_hs = axi_aw_valid_i && aw_ready;
    assign w_hs  = axi_w_valid_i && w_ready;
    assign ar_hs = axi_ar_valid_i && ar_ready;

    // Arriving beats bypass their holding registers so a same-cycle AW+W
    // (or the second of a split pair) commits without an extra cycle.
    assign wr_addr   = aw_held_q ? aw_addr_q : axi_aw_addr_i;
    assign wr_data   = w_held_q ? w_data_q : axi_w_data_i;
    assign wr_strb   = w_held_q ? w_strb_q : axi_w_strb_i;
    assign wr_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_sel    = decode(wr_addr);
    assign rd_sel    = decode(axi_ar_addr_i);

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = axi_aw_addr_i;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = axi_w_data_i;
            w_strb_d = axi_w_strb_i;
        end
        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = (wr_sel == REG_NONE) ? RESP_DECERR : RESP_OKAY;
        end else if (b_valid_q && axi_b_ready_i) begin
            b_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        timer_irq_d = (mtime_q >= mtimecmp_q);
        // A bus write to mtime overrides the increment; the prescaler keeps its phase.
        if (wr_commit) begin
            case (wr_sel)
                REG_MSIP:     if (wr_strb[0]) msip_d = wr_data[0];
                REG_MTIMECMP: mtimecmp_d = merge(mtimecmp_q, wr_data, wr_strb);
                REG_MTIME:    mtime_d = merge(mtime_q, wr_data, wr_strb);
                default:      ;
            endcase
        end
    end

    always_comb begin
        r_valid_d = r_valid_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_resp_d  = (rd_sel == REG_NONE) ? RESP_DECERR : RESP_OKAY;
            case (rd_sel)
                REG_MSIP:     r_data_d = {63'd0, msip_q};
                REG_MTIMECMP: r_data_d = mtimecmp_q;
                REG_MTIME:    r_data_d = mtime_q;
                default:      r_data_d = 64'd0;
            endcase
        end else if (r_valid_q && axi_r_ready_i) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q   <= 1'b0;
            aw_addr_q   <= 64'd0;
            w_held_q    <= 1'b0;
            w_data_q    <= 64'd0;
            w_strb_q    <= 8'd0;
            b_valid_q   <= 1'b0;
            b_resp_q    <= RESP_OKAY;
            r_valid_q   <= 1'b0;
            r_resp_q    <= RESP_OKAY;
            r_data_q    <= 64'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            cnt_q       <= '0;
            timer_irq_q <= 1'b0;
        end else begin
            aw_held_q   <= aw_held_d;
            aw_addr_q   <= aw_addr_d;
            w_held_q    <= w_held_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            b_valid_q   <= b_valid_d;
            b_resp_q    <= b_resp_d;
            r_valid_q   <= r_valid_d;
            r_resp_q    <= r_resp_d;
            r_data_q    <= r_data_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            cnt_q       <= cnt_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign axi_aw_ready_o = aw_ready;
    assign axi_w_ready_o  = w_ready;
    assign axi_b_valid_o  = b_valid_q;
    assign axi_b_resp_o   = b_resp_q;
    assign axi_ar_ready_o = ar_ready;
    assign axi_r_valid_o  = r_valid_q;
    assign axi_r_resp_o   = r_resp_q;
    assign axi_r_data_o   = r_data_q;
    assign timer_irq_o    = timer_irq_q;
    assign soft_irq_o     = msip_q;

endmodule

// File: tb/tb_ysyx_22050019_clint.sv
// Directed bench for the CLINT: one instance at TICK_DIV=1 and one at
// TICK_DIV=3 share the bus inputs so the prescaler can be checked in lockstep.
module tb_ysyx_22050019_clint;

    localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MSIP = BASE + 64'h0000;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        axi_aw_valid_i, axi_w_valid_i, axi_b_ready_i;
    logic        axi_ar_valid_i, axi_r_ready_i;
    logic [63:0] axi_aw_addr_i, axi_w_data_i, axi_ar_addr_i;
    logic [7:0]  axi_w_strb_i;

    logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [63:0] r_data_o;
    logic        timer_irq_o, soft_irq_o;

    logic        aw_ready3, w_ready3, b_valid3, ar_ready3, r_valid3;
    logic [1:0]  b_resp3, r_resp3;
    logic [63:0] r_data3;
    logic        timer_irq3, soft_irq3;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc;

    ysyx_22050019_clint #(.BASE(BASE), .TICK_DIV(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .axi_aw_ready_o(aw_ready_o), .axi_aw_valid_i(axi_aw_valid_i), .axi_aw_addr_i(axi_aw_addr_i),
        .axi_w_ready_o(w_ready_o), .axi_w_valid_i(axi_w_valid_i), .axi_w_data_i(axi_w_data_i),
        .axi_w_strb_i(axi_w_strb_i), .axi_b_ready_i(axi_b_ready_i), .axi_b_valid_o(b_valid_o),
        .axi_b_resp_o(b_resp_o), .axi_ar_ready_o(ar_ready_o), .axi_ar_valid_i(axi_ar_valid_i),
        .axi_ar_addr_i(axi_ar_addr_i), .axi_r_ready_i(axi_r_ready_i), .axi_r_valid_o(r_valid_o),
        .axi_r_resp_o(r_resp_o), .axi_r_data_o(r_data_o),
        .timer_irq_o(timer_irq_o), .soft_irq_o(soft_irq_o)
    );

    ysyx_22050019_clint #(.BASE(BASE), .TICK_DIV(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .axi_aw_ready_o(aw_ready3), .axi_aw_valid_i(axi_aw_valid_i), .axi_aw_addr_i(axi_aw_addr_i),
        .axi_w_ready_o(w_ready3), .axi_w_valid_i(axi_w_valid_i), .axi_w_data_i(axi_w_data_i),
        .axi_w_strb_i(axi_w_strb_i), .axi_b_ready_i(axi_b_ready_i), .axi_b_valid_o(b_valid3),
        .axi_b_resp_o(b_resp3), .axi_ar_ready_o(ar_ready3), .axi_ar_valid_i(axi_ar_valid_i),
        .axi_ar_addr_i(axi_ar_addr_i), .axi_r_ready_i(axi_r_ready_i), .axi_r_valid_o(r_valid3),
        .axi_r_resp_o(r_resp3), .axi_r_data_o(r_data3),
        .timer_irq_o(timer_irq3), .soft_irq_o(soft_irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; with no mtime writes, mtime of the
    // TICK_DIV=1 instance equals this count during the same cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Starts just after a rising edge; W leads AW by w_lead cycles.
    // Returns just after the edge that retires the write response.
    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input int w_lead,
                             output logic [1:0] resp);
        int n;
        bit aw_ok, w_ok, aw_go, w_go;
        aw_ok = 0; w_ok = 0; n = 0;
        axi_aw_addr_i  = addr;
        axi_w_data_i   = data;
        axi_w_strb_i   = strb;
        axi_w_valid_i  = 1'b1;
        axi_aw_valid_i = (w_lead == 0);
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_go = axi_aw_valid_i && aw_ready_o;
            w_go  = axi_w_valid_i && w_ready_o;
            @(posedge clk); #1;
            n++;
            if (aw_go) begin aw_ok = 1; axi_aw_valid_i = 1'b0; end
            if (w_go)  begin w_ok = 1;  axi_w_valid_i  = 1'b0; end
            if (!aw_ok && n >= w_lead) axi_aw_valid_i = 1'b1;
            if (w_ok && !aw_ok) check("w_held_ready", w_ready_o, 1'b0);
        end
        axi_aw_valid_i = 1'b0;
        axi_w_valid_i  = 1'b0;
        check("wr_handshake", 64'(aw_ok && w_ok), 64'd1);
        check("b_latency", b_valid_o, 1'b1);
        resp = b_resp_o;
        @(posedge clk); #1;
        check("b_retire", b_valid_o, 1'b0);
    endtask

    // Returns just after the edge that retires the read (or with r_valid
    // still high when r_ready is low).
    task automatic axi_read(input logic [63:0] addr, output logic [63:0] d,
                            output logic [63:0] d3, output logic [1:0] resp);
        int n;
        bit go;
        check("ar_ready", ar_ready_o, 1'b1);
        axi_ar_addr_i  = addr;
        axi_ar_valid_i = 1'b1;
        n = 0; go = 0;
        while (!go && n < 20) begin
            go = ar_ready_o;
            @(posedge clk); #1;
            n++;
        end
        axi_ar_valid_i = 1'b0;
        check("r_latency", r_valid_o, 1'b1);
        d    = r_data_o;
        d3   = r_data3;
        resp = r_resp_o;
        if (axi_r_ready_i) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [63:0] d, d3, exp;
        logic [1:0]  resp;
        int          n;

        rst_n = 1'b0;
        axi_aw_valid_i = 1'b0; axi_w_valid_i = 1'b0; axi_ar_valid_i = 1'b0;
        axi_aw_addr_i = '0; axi_w_data_i = '0; axi_w_strb_i = '0; axi_ar_addr_i = '0;
        axi_b_ready_i = 1'b1; axi_r_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", aw_ready_o, 1'b1);
        check("rst_w_ready", w_ready_o, 1'b1);
        check("rst_ar_ready", ar_ready_o, 1'b1);
        check("rst_b_valid", b_valid_o, 1'b0);
        check("rst_b_resp", b_resp_o, 2'b00);
        check("rst_r_valid", r_valid_o, 1'b0);
        check("rst_r_resp", r_resp_o, 2'b00);
        check("rst_r_data", r_data_o, 64'd0);
        check("rst_timer_irq", timer_irq_o, 1'b0);
        check("rst_soft_irq", soft_irq_o, 1'b0);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        while (ncyc < 5) begin @(posedge clk); #1; end

        // Idle mtime read: value counts edges since reset.
        exp = 64'(ncyc);
        axi_read(A_TIME, d, d3, resp);
        check("idle_mtime", d, exp);
        check("idle_mtime_resp", resp, 2'b00);
        check("idle_timer_irq", timer_irq_o, 1'b0);

        // W leads AW by one cycle; mtimecmp = 0x10.
        axi_write(A_CMP, 64'h10, 8'hFF, 1, resp);
        check("cmp_wr_resp", resp, 2'b00);
        n = 0;
        while (ncyc != 16 && n < 40) begin @(posedge clk); #1; n++; end
        check("irq_at_reach", timer_irq_o, 1'b0);
        @(posedge clk); #1;
        check("irq_after_reach", timer_irq_o, 1'b1);

        // Partial mtime write: upper word kept, no increment on the write edge.
        axi_write(A_TIME, 64'hAAAA_BBBB_0000_0000, 8'hFF, 0, resp);
        axi_write(A_TIME, 64'h1234_5678_9ABC_DEF0, 8'h0F, 0, resp);
        check("mtime_part_resp", resp, 2'b00);
        axi_read(A_TIME, d, d3, resp);
        check("mtime_merge", d, 64'hAAAA_BBBB_9ABC_DEF1);

        // msip
        axi_write(A_MSIP, 64'h1, 8'hFF, 0, resp);
        check("msip_set", soft_irq_o, 1'b1);
        axi_write(A_MSIP, 64'h0, 8'hFF, 0, resp);
        check("msip_clr", soft_irq_o, 1'b0);
        axi_write(A_MSIP, ONES, 8'h01, 0, resp);
        axi_write(A_MSIP, 64'h0, 8'hFE, 0, resp);
        check("msip_strb_hold", soft_irq_o, 1'b1);
        axi_read(A_MSIP + 64'h4, d, d3, resp);
        check("msip_read", d, 64'h1);

        // Unmapped accesses.
        axi_read(BASE + 64'h8000, d, d3, resp);
        check("unmap_rd_data", d, 64'd0);
        check("unmap_rd_resp", resp, 2'b11);
        axi_write(BASE + 64'h1_0000, 64'h0, 8'hFF, 0, resp);
        check("unmap_wr_resp", resp, 2'b11);
        check("unmap_wr_msip", soft_irq_o, 1'b1);
        axi_write(BASE - 64'h8, 64'h0, 8'hFF, 0, resp);
        check("below_base_resp", resp, 2'b11);

        // Read back-pressure with mtimecmp (offset bits [2:0] ignored).
        axi_r_ready_i = 1'b0;
        axi_read(A_CMP + 64'h4, d, d3, resp);
        check("cmp_read", d, 64'h10);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_r_valid", r_valid_o, 1'b1);
            check("bp_r_data", r_data_o, 64'h10);
            check("bp_ar_ready", ar_ready_o, 1'b0);
        end
        axi_r_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_release", r_valid_o, 1'b0);

        axi_write(A_CMP, ONES, 8'hFF, 0, resp);
        check("irq_drop", timer_irq_o, 1'b0);

        // mtime wrap; TICK_DIV=3 instance starts with its prescaler at 0.
        n = 0;
        while (ncyc % 3 != 0 && n < 5) begin @(posedge clk); #1; n++; end
        axi_write(A_TIME, ONES, 8'hFF, 0, resp);
        axi_read(A_TIME, d, d3, resp);
        check("wrap1_div1", d, 64'd0);
        check("wrap1_div3", d3, ONES);
        axi_read(A_TIME, d, d3, resp);
        check("wrap2_div1", d, 64'd2);
        check("wrap2_div3", d3, 64'd0);

        // Reset with an AW held: it must be dropped.
        axi_aw_addr_i  = A_CMP;
        axi_aw_valid_i = 1'b1;
        @(posedge clk); #1;
        axi_aw_valid_i = 1'b0;
        check("aw_held", aw_ready_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_aw_ready", aw_ready_o, 1'b1);
        check("async_soft_irq", soft_irq_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        axi_w_data_i  = 64'h0;
        axi_w_strb_i  = 8'hFF;
        axi_w_valid_i = 1'b1;
        @(posedge clk); #1;
        axi_w_valid_i = 1'b0;
        @(posedge clk); #1;
        check("dropped_aw_no_b", b_valid_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
